gray_seq_checker: RTL and testbench



---
 rtl/gray_seq_pkg.sv | 25 ++
 rtl/gray_seq_checker.sv | 113 +++++++++++
 tb/tb_gray_seq_checker.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/gray_seq_pkg.sv
// Shared types and helpers for the Gray-sequence checker.
package gray_seq_pkg;

  localparam int GRAY_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCKED
  } state_e;

  // Reflected Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GRAY_W-1:0] gray_to_bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Expected successor; wraps 15 -> 0 by natural truncation.
  function automatic logic [GRAY_W-1:0] next_bin(input logic [GRAY_W-1:0] b);
    return b + GRAY_W'(1);
  endfunction

endpackage

// File: rtl/gray_seq_checker.sv
// Monitors the Gray-coded counter state word, tracks lock on the 16-state
// sequence, and reports sequence errors, wrap events and a saturating error count.
module gray_seq_checker
  import gray_seq_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              sample_valid,
  input  logic [GRAY_W-1:0] gray_in,
  input  logic              clear_err,
  output logic [GRAY_W-1:0] bin_out,
  output logic              bin_valid,
  output logic              locked,
  output logic              seq_err,
  output logic              wrap,
  output logic [ERR_W-1:0]  err_count
);

  state_e            state_q, state_d;
  logic [3:0]        good_cnt_q, good_cnt_d;
  logic [GRAY_W-1:0] prev_q, prev_d;
  logic [GRAY_W-1:0] bin_q, bin_d;
  logic              bin_valid_q, bin_valid_d;
  logic              seq_err_q, seq_err_d;
  logic              wrap_q, wrap_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

  logic [GRAY_W-1:0] cur;
  logic              succ;
  logic              stall;

  assign cur   = gray_to_bin(gray_in);
  assign succ  = (cur == next_bin(prev_q));
  assign stall = (cur == prev_q);

  // Next-state, counters and pulse outputs; clear_err applies before a same-cycle error is counted.
  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    prev_d      = prev_q;
    bin_d       = bin_q;
    bin_valid_d = 1'b0;
    seq_err_d   = 1'b0;
    wrap_d      = 1'b0;
    err_cnt_d   = clear_err ? '0 : err_cnt_q;

    if (sample_valid) begin
      bin_d       = cur;
      bin_valid_d = 1'b1;
      prev_d      = cur;  // error samples also become the new reference
      unique case (state_q)
        IDLE: begin
          state_d    = ACQ;
          good_cnt_d = '0;
        end
        ACQ: begin
          if (succ) begin
            wrap_d     = (prev_q == '1);
            good_cnt_d = good_cnt_q + 4'd1;
            if (good_cnt_d == 4'(LOCK_COUNT)) state_d = LOCKED;
          end else if (!stall) begin
            good_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (succ) begin
            wrap_d = (prev_q == '1);
          end else if (!stall) begin
            seq_err_d  = 1'b1;
            if (err_cnt_d != '1) err_cnt_d = err_cnt_d + ERR_W'(1);
            state_d    = ACQ;
            good_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      good_cnt_q  <= '0;
      prev_q      <= '0;
      bin_q       <= '0;
      bin_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
      wrap_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      prev_q      <= prev_d;
      bin_q       <= bin_d;
      bin_valid_q <= bin_valid_d;
      seq_err_q   <= seq_err_d;
      wrap_q      <= wrap_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bin_out   = bin_q;
  assign bin_valid = bin_valid_q;
  assign locked    = (state_q == LOCKED);
  assign seq_err   = seq_err_q;
  assign wrap      = wrap_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_gray_seq_checker.sv
// Directed bench for gray_seq_checker with a cycle-level reference model.
module tb_gray_seq_checker;

  localparam int LOCK = 4;
  localparam int EW   = 2;
  localparam int EMAX = (1 << EW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          sample_valid = 1'b0;
  logic [3:0]    gray_in = '0;
  logic          clear_err = 1'b0;
  logic [3:0]    bin_out;
  logic          bin_valid, locked, seq_err, wrap;
  logic [EW-1:0] err_count;

  gray_seq_checker #(.LOCK_COUNT(LOCK), .ERR_W(EW)) dut (
    .CLK(CLK), .RST(RST), .sample_valid(sample_valid), .gray_in(gray_in),
    .clear_err(clear_err), .bin_out(bin_out), .bin_valid(bin_valid),
    .locked(locked), .seq_err(seq_err), .wrap(wrap), .err_count(err_count)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;
  int p = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] gray_of(input int b);
    return 4'(b ^ (b >> 1));
  endfunction

  // Inverse by search over the 16 codes.
  function automatic int bin_of(input logic [3:0] g);
    for (int b = 0; b < 16; b++) if (gray_of(b) == g) return b;
    return -1;
  endfunction

  // Reference model: remembers the previous value, the run of good steps and lock.
  int  m_bin = 0, m_errs = 0, m_prev = 0, m_run = 0;
  bit  m_bv = 0, m_se = 0, m_wr = 0, m_lk = 0, m_have = 0;

  always @(posedge CLK) begin
    int b;
    if (RST) begin
      m_bin = 0; m_errs = 0; m_prev = 0; m_run = 0;
      m_bv = 0; m_se = 0; m_wr = 0; m_lk = 0; m_have = 0;
    end else begin
      m_bv = 0; m_se = 0; m_wr = 0;
      if (clear_err) m_errs = 0;
      if (sample_valid) begin
        b = bin_of(gray_in);
        m_bin = b;
        m_bv = 1;
        if (!m_have) begin
          m_have = 1;
          m_run = 0;
        end else if (b == m_prev) begin
          // stall: nothing changes
        end else if (b == (m_prev + 1) % 16) begin
          if (m_prev == 15) m_wr = 1;
          m_run++;
          if (m_run >= LOCK) m_lk = 1;
        end else begin
          if (m_lk) begin
            m_se = 1;
            m_errs = (m_errs + 1 > EMAX) ? EMAX : m_errs + 1;
          end
          m_lk = 0;
          m_run = 0;
        end
        m_prev = b;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("m_bin_out", bin_out, m_bin);
      chk("m_bin_valid", bin_valid, m_bv);
      chk("m_locked", locked, m_lk);
      chk("m_seq_err", seq_err, m_se);
      chk("m_wrap", wrap, m_wr);
      chk("m_err_count", err_count, m_errs);
    end
  end

  // Drive one sample starting at a negedge; returns at the next negedge with outputs settled.
  task automatic smp(input logic [3:0] g);
    sample_valid = 1'b1;
    gray_in = g;
    @(negedge CLK);
    sample_valid = 1'b0;
  endtask

  task automatic smp_b(input int b);
    p = b % 16;
    smp(gray_of(p));
  endtask

  task automatic do_reset();
    RST = 1'b1;
    sample_valid = 1'b0;
    clear_err = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bin_out"}, bin_out, 0);
    chk({tag, "_bin_valid"}, bin_valid, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_seq_err"}, seq_err, 0);
    chk({tag, "_wrap"}, wrap, 0);
    chk({tag, "_err_count"}, err_count, 0);
  endtask

  initial begin
    @(negedge CLK);
    do_reset();
    chk_en = 1;
    chk_zero("reset");

    // 1: full sequence plus wrap
    for (int i = 0; i <= 16; i++) begin
      smp_b(i);
      chk("t1_bin", bin_out, i % 16);
      chk("t1_locked", locked, (i >= 4) ? 1 : 0);
      chk("t1_wrap", wrap, (i == 16) ? 1 : 0);
      chk("t1_seq_err", seq_err, 0);
    end

    // 2: wrong successor while locked, then re-lock from the bad value
    smp(4'b0001);
    smp(4'b0011);
    smp(4'b0110);
    chk("t2_seq_err", seq_err, 1);
    chk("t2_err_count", err_count, 1);
    chk("t2_locked", locked, 0);
    smp(4'b0111); smp(4'b0101); smp(4'b0100);
    chk("t2_not_yet", locked, 0);
    smp(4'b1100);
    chk("t2_relock", locked, 1);

    // 3: stall while locked
    do_reset();
    for (int i = 0; i <= 5; i++) smp_b(i);
    chk("t3_locked_a", locked, 1);
    chk("t3_bin_a", bin_out, 5);
    smp(4'b0111);
    chk("t3_bin_b", bin_out, 5);
    chk("t3_bv_b", bin_valid, 1);
    chk("t3_locked_b", locked, 1);
    chk("t3_seq_err_b", seq_err, 0);

    // 4: saturation with ERR_W=2
    for (int k = 0; k < 5; k++) begin
      smp_b(p + 5);
      chk("t4_seq_err", seq_err, 1);
      chk("t4_err_count", err_count, (k + 1 > 3) ? 3 : k + 1);
      for (int j = 0; j < 4; j++) smp_b(p + 1);
      chk("t4_relock", locked, 1);
    end

    // 5: clear together with an error, then clear alone
    clear_err = 1'b1;
    smp_b(p + 5);
    clear_err = 1'b0;
    chk("t5_seq_err", seq_err, 1);
    chk("t5_err_after_clear", err_count, 1);
    clear_err = 1'b1;
    @(negedge CLK);
    clear_err = 1'b0;
    chk("t5_clear_alone", err_count, 0);

    // 6: reset while locked with err_count=2
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) smp_b(p + 1);
      smp_b(p + 7);
    end
    for (int j = 0; j < 4; j++) smp_b(p + 1);
    chk("t6_locked_pre", locked, 1);
    chk("t6_err_pre", err_count, 2);
    RST = 1'b1;
    sample_valid = 1'b1;
    gray_in = gray_of(p + 1);
    @(negedge CLK);
    RST = 1'b0;
    sample_valid = 1'b0;
    chk_zero("t6_rst");
    smp(4'b1100);
    chk("t6_bin8", bin_out, 8);
    smp(4'b0000);
    chk("t6_seq_err", seq_err, 0);
    chk("t6_locked", locked, 0);
    chk("t6_wrap", wrap, 0);
    chk("t6_bin0", bin_out, 0);

    @(negedge CLK);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
